// File: rtl/spi_master_param.sv
// Parametrised SPI master: one DATA_W-bit full-duplex word per request, CPOL/CPHA per transfer.
// Optional SPI_MASTER_LSB_FIRST_EN adds the lsbFirst input for LSB-first shifting.
module spi_master_param #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int NUM_CS  = 2,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sendStart,
  input  logic [DATA_W-1:0] sendData,
  input  logic [CS_W-1:0]   csSel,
  input  logic              cpol,
  input  logic              cpha,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic              lsbFirst,
`endif
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] recvData,
  output logic              SPI_SCLK,
  output logic [NUM_CS-1:0] SPI_CS,
  output logic              SPI_MOSI,
  input  logic              SPI_MISO
);
  // state | meaning
  // IDLE  | CS high, SCLK follows cpol, waiting for sendStart
  // SETUP | CS low, first bit on MOSI (cpha=0), before the first SCLK edge
  // SHIFT | producing the 2*DATA_W SCLK edges
  // HOLD  | SCLK back at idle level, CS still low before release
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE  = EDGE_W'(2 * DATA_W);
  localparam logic [CS_W:0]     NUM_CS_V   = (CS_W + 1)'(NUM_CS);
  localparam logic [NUM_CS-1:0] CS_ONE     = NUM_CS'(1);

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [EDGE_W-1:0]   edge_q, edge_d, edge_k;
  logic [DATA_W-1:0]   tx_q, tx_d, rx_q, rx_d, recv_q, recv_d;
  logic                cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, lsb_in;
  logic                sclk_q, sclk_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
  logic [NUM_CS-1:0]   cs_q, cs_d;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_in = lsbFirst;
`else
  assign lsb_in = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    edge_d  = edge_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    recv_d  = recv_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    edge_k  = edge_q + EDGE_W'(1);
    case (state_q)
      IDLE: begin
        sclk_d = cpol;
        cs_d   = '1;
        busy_d = 1'b0;
        if (sendStart && ({1'b0, csSel} < NUM_CS_V)) begin
          state_d = SETUP;
          busy_d  = 1'b1;
          cs_d    = ~(CS_ONE << csSel);
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsb_d   = lsb_in;
          div_d   = DIV_RELOAD;
          edge_d  = '0;
          rx_d    = '0;
          tx_d    = sendData;
          // cpha=0 slaves sample on the first edge, so the first bit goes out with CS
          if (!cpha) begin
            mosi_d = lsb_in ? sendData[0] : sendData[DATA_W-1];
            tx_d   = lsb_in ? (sendData >> 1) : (sendData << 1);
          end
        end
      end
      SETUP, SHIFT: begin
        if (div_q != '0) begin
          div_d = div_q - DIV_W'(1);
        end else begin
          div_d  = DIV_RELOAD;
          sclk_d = ~sclk_q;
          edge_d = edge_k;
          // odd edges are leading; sample on leading when cpha=0, trailing when cpha=1
          if (edge_k[0] != cpha_q) begin
            rx_d = lsb_q ? {SPI_MISO, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], SPI_MISO};
          end else if (edge_k != LAST_EDGE) begin
            mosi_d = lsb_q ? tx_q[0] : tx_q[DATA_W-1];
            tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
          end
          state_d = (edge_k == LAST_EDGE) ? HOLD : SHIFT;
        end
      end
      HOLD: begin
        sclk_d = cpol_q;
        if (div_q != '0) begin
          div_d = div_q - DIV_W'(1);
        end else begin
          state_d = IDLE;
          cs_d    = '1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          recv_d  = rx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      recv_q  <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      sclk_q  <= 1'b0;
      cs_q    <= '1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      recv_q  <= recv_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign recvData = recv_q;
  assign SPI_SCLK = sclk_q;
  assign SPI_CS   = cs_q;
  assign SPI_MOSI = mosi_q;
endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: protocol-level SPI slave models check data, chip select and timing.
`timescale 1ns/1ps
module tb_spi_master_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;
  localparam int LAT_A = 1 + (2 * 8 + 1) * 4;
  localparam int LAT_B = 1 + (2 * 16 + 1) * 2;

  // instance A: 8 bits, divide by 4, three chip selects
  logic       a_start = 1'b0, a_cpol = 1'b0, a_cpha = 1'b0, a_lsb = 1'b0;
  logic [7:0] a_data = 8'h00;
  logic [1:0] a_sel = 2'd0;
  logic       a_busy, a_done, a_sclk, a_mosi, a_miso;
  logic [7:0] a_recv;
  logic [2:0] a_cs;

  spi_master_param #(.DATA_W(8), .CLK_DIV(4), .NUM_CS(3)) u_a (
    .clk(clk), .rst(rst), .sendStart(a_start), .sendData(a_data), .csSel(a_sel),
    .cpol(a_cpol), .cpha(a_cpha),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsbFirst(a_lsb),
`endif
    .busy(a_busy), .done(a_done), .recvData(a_recv), .SPI_SCLK(a_sclk),
    .SPI_CS(a_cs), .SPI_MOSI(a_mosi), .SPI_MISO(a_miso));

  // instance B: 16 bits, divide by 2, two chip selects
  logic        b_start = 1'b0, b_cpol = 1'b0, b_cpha = 1'b0, b_lsb = 1'b0;
  logic [15:0] b_data = 16'h0000;
  logic        b_sel = 1'b0;
  logic        b_busy, b_done, b_sclk, b_mosi, b_miso;
  logic [15:0] b_recv;
  logic [1:0]  b_cs;

  spi_master_param #(.DATA_W(16), .CLK_DIV(2), .NUM_CS(2)) u_b (
    .clk(clk), .rst(rst), .sendStart(b_start), .sendData(b_data), .csSel(b_sel),
    .cpol(b_cpol), .cpha(b_cpha),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsbFirst(b_lsb),
`endif
    .busy(b_busy), .done(b_done), .recvData(b_recv), .SPI_SCLK(b_sclk),
    .SPI_CS(b_cs), .SPI_MOSI(b_mosi), .SPI_MISO(b_miso));

  // slave A: MSB-first shift register, reacts only to SCLK transitions while selected
  logic [7:0] sa_word = 8'h00, sa_rx = 8'h00;
  logic       sa_cpol = 1'b0, sa_cpha = 1'b0, sa_sclk_prev = 1'b0, sa_lead;
  logic [2:0] sa_cs_prev = 3'b111;
  int         sa_idx = 0, sa_edges = 0, sa_rises = 0;

  always @(a_sclk or a_cs) begin
    if (&sa_cs_prev && !(&a_cs)) begin
      sa_idx = 0; sa_rx = 8'h00; sa_edges = 0; sa_rises = 0;
      if (!sa_cpha) begin a_miso = sa_word[7]; sa_idx = 1; end
    end else if (!(&a_cs) && a_sclk !== sa_sclk_prev) begin
      sa_lead = (sa_sclk_prev === sa_cpol);
      sa_edges++;
      if (a_sclk) sa_rises++;
      if (sa_lead != sa_cpha) sa_rx = {sa_rx[6:0], a_mosi};
      else if (sa_idx < 8) begin a_miso = sa_word[7 - sa_idx]; sa_idx++; end
    end
    sa_cs_prev   = a_cs;
    sa_sclk_prev = a_sclk;
  end

  logic [15:0] sb_word = 16'h0000, sb_rx = 16'h0000;
  logic        sb_cpol = 1'b0, sb_cpha = 1'b0, sb_sclk_prev = 1'b0, sb_lead;
  logic [1:0]  sb_cs_prev = 2'b11;
  int          sb_idx = 0, sb_rises = 0;

  always @(b_sclk or b_cs) begin
    if (&sb_cs_prev && !(&b_cs)) begin
      sb_idx = 0; sb_rx = 16'h0000; sb_rises = 0;
      if (!sb_cpha) begin b_miso = sb_word[15]; sb_idx = 1; end
    end else if (!(&b_cs) && b_sclk !== sb_sclk_prev) begin
      sb_lead = (sb_sclk_prev === sb_cpol);
      if (b_sclk) sb_rises++;
      if (sb_lead != sb_cpha) sb_rx = {sb_rx[14:0], b_mosi};
      else if (sb_idx < 16) begin b_miso = sb_word[15 - sb_idx]; sb_idx++; end
    end
    sb_cs_prev   = b_cs;
    sb_sclk_prev = b_sclk;
  end

  int t0_a, t0_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7 - i];
    return r;
  endfunction

  task automatic wait_done_a(output int lat);
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      if (a_done) begin lat = cyc - t0_a; break; end
      @(negedge clk);
    end
  endtask

  task automatic start_a(input logic [7:0] d, input logic [1:0] sel, input logic cp,
                         input logic ch, input logic [7:0] sw);
    a_data = d; a_sel = sel; a_cpol = cp; a_cpha = ch;
    sa_word = sw; sa_cpol = cp; sa_cpha = ch;
    repeat (2) @(negedge clk);
    a_start = 1'b1;
    t0_a = cyc;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic run_a(input string tag, input logic [7:0] d, input logic [1:0] sel,
                       input logic cp, input logic ch, input logic [7:0] sw);
    int lat;
    logic [2:0] cs_exp;
    cs_exp = 3'b111;
    cs_exp[sel] = 1'b0;
    start_a(d, sel, cp, ch, sw);
    chk({tag, "_cs"}, 32'(a_cs), 32'(cs_exp));
    chk({tag, "_busy"}, 32'(a_busy), 32'd1);
    if (!ch) chk({tag, "_mosi0"}, 32'(a_mosi), 32'(a_lsb ? d[0] : d[7]));
    wait_done_a(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(LAT_A));
    chk({tag, "_recv"}, 32'(a_recv), 32'(a_lsb ? rev8(sw) : sw));
    chk({tag, "_slave"}, 32'(sa_rx), 32'(a_lsb ? rev8(d) : d));
    chk({tag, "_rises"}, 32'(sa_rises), 32'd8);
    chk({tag, "_edges"}, 32'(sa_edges), 32'd16);
    chk({tag, "_csdone"}, 32'(a_cs), 32'h7);
    chk({tag, "_sclkidle"}, 32'(a_sclk), 32'(cp));
  endtask

  initial begin
    int lat;
    int seen_busy, seen_done, seen_cs;
    logic [7:0] rd, rs;
    logic [1:0] rsel;
    logic rcp, rch;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_recv", 32'(a_recv), 32'd0);
    chk("rst_sclk", 32'(a_sclk), 32'd0);
    chk("rst_cs", 32'(a_cs), 32'h7);
    chk("rst_mosi", 32'(a_mosi), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_a("mode0", 8'hC2, 2'd0, 1'b0, 1'b0, 8'h83);
    run_a("mode3", 8'hA5, 2'd1, 1'b1, 1'b1, 8'h3C);
    a_cpol = 1'b0; a_cpha = 1'b0;

    // 16-bit instance, mode 1
    b_data = 16'hBEEF; b_sel = 1'b0; b_cpol = 1'b0; b_cpha = 1'b1;
    sb_word = 16'h1234; sb_cpol = 1'b0; sb_cpha = 1'b1;
    repeat (2) @(negedge clk);
    b_start = 1'b1;
    t0_b = cyc;
    @(negedge clk);
    b_start = 1'b0;
    chk("w16_cs", 32'(b_cs), 32'h2);
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      if (b_done) begin lat = cyc - t0_b; break; end
      @(negedge clk);
    end
    chk("w16_lat", 32'(lat), 32'(LAT_B));
    chk("w16_recv", 32'(b_recv), 32'h1234);
    chk("w16_slave", 32'(sb_rx), 32'hBEEF);
    chk("w16_rises", 32'(sb_rises), 32'd16);

    // sendStart held through a transfer and into its done cycle
    a_data = 8'h96; a_sel = 2'd2; sa_word = 8'h69; sa_cpol = 1'b0; sa_cpha = 1'b0;
    repeat (2) @(negedge clk);
    a_start = 1'b1;
    t0_a = cyc;
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (a_done) begin lat = cyc - t0_a; break; end
    end
    chk("b2b_lat1", 32'(lat), 32'(LAT_A));
    chk("b2b_csgap", 32'(a_cs), 32'h7);
    chk("b2b_recv1", 32'(a_recv), 32'h69);
    @(negedge clk);
    a_start = 1'b0;
    t0_a = cyc - 1;
    chk("b2b_cs2", 32'(a_cs), 32'h3);
    chk("b2b_busy2", 32'(a_busy), 32'd1);
    wait_done_a(lat);
    chk("b2b_lat2", 32'(lat), 32'(LAT_A));
    chk("b2b_slave2", 32'(sa_rx), 32'h96);

    // out-of-range chip select is dropped
    a_sel = 2'd3;
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    seen_busy = 0; seen_done = 0; seen_cs = 0;
    for (int i = 0; i < 12; i++) begin
      if (a_busy) seen_busy++;
      if (a_done) seen_done++;
      if (a_cs !== 3'b111) seen_cs++;
      @(negedge clk);
    end
    chk("drop_busy", 32'(seen_busy), 32'd0);
    chk("drop_done", 32'(seen_done), 32'd0);
    chk("drop_cs", 32'(seen_cs), 32'd0);

    // reset in the middle of a transfer
    start_a(8'hE7, 2'd0, 1'b0, 1'b0, 8'h18);
    while (cyc < t0_a + 30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_cs", 32'(a_cs), 32'h7);
    chk("mrst_sclk", 32'(a_sclk), 32'd0);
    chk("mrst_busy", 32'(a_busy), 32'd0);
    chk("mrst_recv", 32'(a_recv), 32'd0);
    seen_done = 0;
    for (int i = 0; i < 80; i++) begin
      if (a_done) seen_done++;
      @(negedge clk);
    end
    chk("mrst_nodone", 32'(seen_done), 32'd0);
    run_a("post_rst", 8'h5A, 2'd0, 1'b0, 1'b0, 8'hC3);

    for (int n = 0; n < 6; n++) begin
      rd   = 8'($urandom);
      rs   = 8'($urandom);
      rsel = 2'($urandom_range(0, 2));
      rcp  = 1'($urandom);
      rch  = 1'($urandom);
      run_a("rnd", rd, rsel, rcp, rch, rs);
    end
    a_cpol = 1'b0; a_cpha = 1'b0;

`ifdef SPI_MASTER_LSB_FIRST_EN
    a_lsb = 1'b1;
    run_a("lsb", 8'h01, 2'd0, 1'b0, 1'b0, 8'h80);
    a_lsb = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
